fix_length_packet_framer: RTL and testbench

//  - Parametrised successor of the fixed-1024 byte packetiser: frames an Avalon-ST symbol stream into

---
 rtl/fix_length_framer_pkg.sv | 30 +++
 rtl/st_skid_buffer.sv | 76 +++++++
 rtl/fix_length_packet_framer.sv | 146 ++++++++++++++
 tb/tb_fix_length_packet_framer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fix_length_framer_pkg.sv
// ============================================================================
// fix_length_framer_pkg : shared types and field layout for the packet framer
// Rev 1.0
// ============================================================================
`default_nettype none

package fix_length_framer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IN_PKT = 2'd1,
    PAD    = 2'd2
  } framer_state_e;

  // Output word layout: {real, imag, flag}
  localparam int FLAG_BIT = 0;
  localparam int IMAG_LSB = 1;

  function automatic int real_lsb(input int sym_w);
    return IMAG_LSB + sym_w;
  endfunction

  // A one-beat packet still needs a 1-bit counter to stay legal
  function automatic int cnt_width(input int pkt_len);
    return (pkt_len > 1) ? $clog2(pkt_len) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/st_skid_buffer.sv
// ============================================================================
// st_skid_buffer : 2-entry ready/valid buffer with a registered output stage
// Rev 1.0
// ============================================================================
`default_nettype none

module st_skid_buffer #(
  parameter int DW = 19
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  logic [1:0]    count_q, count_d;
  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;
  logic          push, pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;

  always_comb begin
    push    = in_valid && in_ready;
    pop     = out_valid && out_ready;
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = in_data;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = in_data;
        end else if (push) begin
          tail_d  = in_data;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        // Full: the held word slides into the output register as it drains
        if (pop) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fix_length_packet_framer.sv
// ============================================================================
// fix_length_packet_framer : frames a symbol stream into PKT_LEN-beat packets
// Optional pad-to-end flush enabled by defining FRAMER_PAD_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module fix_length_packet_framer
  import fix_length_framer_pkg::*;
#(
  parameter int SYM_W   = 8,
  parameter int PKT_LEN = 1024,
  parameter int IQ_MODE = 0
) (
  input  logic             clock_clk,
  input  logic             reset_reset_n,
  input  logic [SYM_W-1:0] asi_in0_data,
  input  logic             asi_in0_valid,
  output logic             asi_in0_ready,
  output logic [2*SYM_W:0] aso_out0_data,
  output logic             aso_out0_valid,
  input  logic             aso_out0_ready,
  output logic             aso_out0_startofpacket,
  output logic             aso_out0_endofpacket,
  output logic             aso_out0_empty,
  output logic [15:0]      pkt_cnt_o
`ifdef FRAMER_PAD_EN
  ,
  input  logic             flush_i
`endif
);

  localparam int               CNT_W    = cnt_width(PKT_LEN);
  localparam int               DW       = 2*SYM_W + 3;
  localparam int               REAL_LSB = real_lsb(SYM_W);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(PKT_LEN - 1);

  framer_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic [SYM_W-1:0] i_hold_q, i_hold_d;
  logic             ready_en_q, ready_en_d;
  logic [15:0]      pkt_cnt_q, pkt_cnt_d;

  logic             in_ready, in_fire;
  logic             beat_valid, beat_sop, beat_eop;
  logic [SYM_W-1:0] beat_real, beat_imag;
  logic [2*SYM_W:0] beat_data;
  logic             buf_in_ready;
  logic [DW-1:0]    buf_out;

  always_comb begin
    // Input is held off during reset recovery and while padding
    in_ready   = ready_en_q && buf_in_ready && (state_q != PAD);
    in_fire    = asi_in0_valid && in_ready;
    beat_valid = 1'b0;
    beat_real  = '0;
    beat_imag  = '0;
    if (state_q == PAD) begin
      beat_valid = buf_in_ready;
      beat_real  = phase_q ? i_hold_q : '0;
    end else if (in_fire) begin
      if (IQ_MODE == 0) begin
        beat_valid = 1'b1;
        beat_real  = asi_in0_data;
      end else if (phase_q) begin
        beat_valid = 1'b1;
        beat_real  = i_hold_q;
        beat_imag  = asi_in0_data;
      end
    end

    beat_data                       = '0;
    beat_data[REAL_LSB +: SYM_W]    = beat_real;
    beat_data[IMAG_LSB +: SYM_W]    = beat_imag;
    beat_data[FLAG_BIT]             = 1'b1;
    beat_sop                        = (cnt_q == '0);
    beat_eop                        = (cnt_q == LAST);

    phase_d  = phase_q;
    i_hold_d = i_hold_q;
    if (state_q == PAD) begin
      if (beat_valid) phase_d = 1'b0;
    end else if (in_fire && (IQ_MODE != 0)) begin
      phase_d = !phase_q;
      if (!phase_q) i_hold_d = asi_in0_data;
    end

    cnt_d = cnt_q;
    if (beat_valid) cnt_d = beat_eop ? '0 : cnt_q + CNT_W'(1);

    state_d = state_q;
    if (beat_valid) begin
      if (beat_eop)              state_d = IDLE;
      else if (state_q == IDLE)  state_d = IN_PKT;
    end
`ifdef FRAMER_PAD_EN
    if ((state_q == IN_PKT) && flush_i && !(beat_valid && beat_eop)) state_d = PAD;
`endif

    ready_en_d = 1'b1;
    pkt_cnt_d  = pkt_cnt_q;
    if (aso_out0_valid && aso_out0_ready && aso_out0_endofpacket) pkt_cnt_d = pkt_cnt_q + 16'd1;
  end

  always_ff @(posedge clock_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      i_hold_q   <= '0;
      ready_en_q <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      i_hold_q   <= i_hold_d;
      ready_en_q <= ready_en_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  st_skid_buffer #(
    .DW(DW)
  ) u_skid (
    .clk       (clock_clk),
    .rst_n     (reset_reset_n),
    .in_data   ({beat_data, beat_sop, beat_eop}),
    .in_valid  (beat_valid),
    .in_ready  (buf_in_ready),
    .out_data  (buf_out),
    .out_valid (aso_out0_valid),
    .out_ready (aso_out0_ready)
  );

  assign asi_in0_ready          = in_ready;
  assign aso_out0_data          = buf_out[DW-1:2];
  assign aso_out0_startofpacket = buf_out[1];
  assign aso_out0_endofpacket   = buf_out[0];
  assign aso_out0_empty         = 1'b0;
  assign pkt_cnt_o              = pkt_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fix_length_packet_framer.sv
// ============================================================================
// tb_fix_length_packet_framer : self-checking bench for fix_length_packet_framer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fix_length_packet_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  in_data [3];
  logic [16:0] out_data [3];
  logic [15:0] pkt_cnt [3];
  logic [2:0]  in_valid, in_ready, out_valid, out_ready, out_sop, out_eop, out_empty, flush;

  fix_length_packet_framer #(.SYM_W(8), .PKT_LEN(4), .IQ_MODE(0)) dut0 (
    .clock_clk(clk), .reset_reset_n(rst_n),
    .asi_in0_data(in_data[0]), .asi_in0_valid(in_valid[0]), .asi_in0_ready(in_ready[0]),
    .aso_out0_data(out_data[0]), .aso_out0_valid(out_valid[0]), .aso_out0_ready(out_ready[0]),
    .aso_out0_startofpacket(out_sop[0]), .aso_out0_endofpacket(out_eop[0]),
    .aso_out0_empty(out_empty[0]), .pkt_cnt_o(pkt_cnt[0])
`ifdef FRAMER_PAD_EN
    , .flush_i(flush[0])
`endif
  );

  fix_length_packet_framer #(.SYM_W(8), .PKT_LEN(2), .IQ_MODE(1)) dut1 (
    .clock_clk(clk), .reset_reset_n(rst_n),
    .asi_in0_data(in_data[1]), .asi_in0_valid(in_valid[1]), .asi_in0_ready(in_ready[1]),
    .aso_out0_data(out_data[1]), .aso_out0_valid(out_valid[1]), .aso_out0_ready(out_ready[1]),
    .aso_out0_startofpacket(out_sop[1]), .aso_out0_endofpacket(out_eop[1]),
    .aso_out0_empty(out_empty[1]), .pkt_cnt_o(pkt_cnt[1])
`ifdef FRAMER_PAD_EN
    , .flush_i(flush[1])
`endif
  );

  fix_length_packet_framer #(.SYM_W(8), .PKT_LEN(1), .IQ_MODE(0)) dut2 (
    .clock_clk(clk), .reset_reset_n(rst_n),
    .asi_in0_data(in_data[2]), .asi_in0_valid(in_valid[2]), .asi_in0_ready(in_ready[2]),
    .aso_out0_data(out_data[2]), .aso_out0_valid(out_valid[2]), .aso_out0_ready(out_ready[2]),
    .aso_out0_startofpacket(out_sop[2]), .aso_out0_endofpacket(out_eop[2]),
    .aso_out0_empty(out_empty[2]), .pkt_cnt_o(pkt_cnt[2])
`ifdef FRAMER_PAD_EN
    , .flush_i(flush[2])
`endif
  );

  int          checks = 0;
  int          errors = 0;
  int          plen [3] = '{4, 2, 1};
  bit          iqm  [3] = '{1'b0, 1'b1, 1'b0};
  int          beat_idx [3];
  logic [15:0] exp_pkt [3];
  bit          hold_v [3];
  logic [7:0]  hold_w [3];
  logic [18:0] exp_q [$];
  logic [18:0] obs_log [$];
  logic [7:0]  src_q [$];
  bit          pad_mode = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected beat = {real, imag, flag, sop, eop}; position in packet from running beat index
  function automatic void push_beat(input int d, input logic [7:0] re, input logic [7:0] im);
    int pos;
    pos = beat_idx[d] % plen[d];
    beat_idx[d]++;
    exp_q.push_back({re, im, 1'b1, pos == 0, pos == plen[d] - 1});
  endfunction

  function automatic bit accept(input int d, input logic [7:0] w);
    if (!iqm[d]) begin
      push_beat(d, w, 8'h00);
      return 1'b1;
    end
    if (!hold_v[d]) begin
      hold_v[d] = 1'b1;
      hold_w[d] = w;
      return 1'b0;
    end
    hold_v[d] = 1'b0;
    push_beat(d, hold_w[d], w);
    return 1'b1;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 3; d++) begin
      beat_idx[d] = 0;
      exp_pkt[d]  = 16'd0;
      hold_v[d]   = 1'b0;
      hold_w[d]   = 8'h00;
    end
    exp_q.delete();
  endfunction

  task automatic chk_zero(input int d);
    chk("rst_valid", out_valid[d], 0);
    chk("rst_sop", out_sop[d], 0);
    chk("rst_eop", out_eop[d], 0);
    chk("rst_data", out_data[d], 0);
    chk("rst_in_ready", in_ready[d], 0);
    chk("rst_pkt_cnt", pkt_cnt[d], 0);
  endtask

  // Entered and left at posedge+1; checks every cycle against the model
  task automatic run(input int d, input int gap, input bit stall, input int budget);
    bit          vin = 1'b0;
    logic [7:0]  w = 8'h00;
    int          cyc = 0;
    int          occ = 0;
    bit          was_stall = 1'b0;
    bit          popped, formed;
    logic [18:0] cur, e;
    logic [18:0] prev = '0;
    obs_log.delete();
    while ((src_q.size() > 0 || vin || exp_q.size() > 0) && cyc < budget) begin
      if (!vin && src_q.size() > 0 && $urandom_range(99) >= gap) begin
        vin = 1'b1;
        w   = src_q.pop_front();
      end
      in_valid[d]  = vin;
      in_data[d]   = vin ? w : 8'($urandom);
      out_ready[d] = stall ? ($urandom_range(2) == 0) : 1'b1;
      @(negedge clk);
      cur = {out_data[d], out_sop[d], out_eop[d]};
      chk("empty", out_empty[d], 0);
      chk("pkt_cnt", pkt_cnt[d], exp_pkt[d]);
      if (pad_mode) begin
        if (!(out_valid[d] && out_eop[d])) chk("pad_ready", in_ready[d], 0);
      end else begin
        chk("in_ready", in_ready[d], occ < 2);
      end
      if (was_stall) begin
        chk("stall_valid", out_valid[d], 1);
        chk("stall_beat", cur, prev);
      end
      popped = 1'b0;
      formed = 1'b0;
      if (out_valid[d] && out_ready[d]) begin
        popped = 1'b1;
        obs_log.push_back(cur);
        if (exp_q.size() == 0) begin
          chk("extra_beat", out_valid[d], 0);
        end else begin
          e = exp_q.pop_front();
          chk("beat", cur, e);
          if (e[0]) exp_pkt[d]++;
        end
      end
      was_stall = out_valid[d] && !out_ready[d];
      prev      = cur;
      if (vin && in_ready[d]) begin
        formed = accept(d, w);
        vin    = 1'b0;
      end
      occ = occ + int'(formed) - int'(popped);
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid[d] = 1'b0;
    chk("drained", exp_q.size(), 0);
    @(negedge clk);
    chk("idle_after", out_valid[d], 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    flush     = '0;
    for (int d = 0; d < 3; d++) in_data[d] = 8'h00;
    model_reset();
    #2;
    for (int d = 0; d < 3; d++) chk_zero(d);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    chk("ready_before_clk", in_ready[0], 0);
    @(posedge clk);
    #1;
    chk("ready_after_clk", in_ready[0], 1);

    // Real-only, full rate, words 01..08
    for (int i = 1; i <= 8; i++) src_q.push_back(8'(i));
    run(0, 0, 1'b0, 100);
    chk("first_beat", obs_log[0], {17'h00201, 2'b10});
    chk("beat3_eop", obs_log[3], {17'h00801, 2'b01});
    chk("beat4_sop", obs_log[4], {17'h00A01, 2'b10});
    chk("pkt_cnt_2", pkt_cnt[0], 16'd2);

    // Random gaps with output ready high about 1 cycle in 3
    for (int i = 0; i < 48; i++) src_q.push_back(8'($urandom));
    run(0, 30, 1'b1, 2000);

    // Interleaved I/Q, PKT_LEN=2
    src_q.push_back(8'hA5);
    src_q.push_back(8'h5A);
    src_q.push_back(8'h11);
    src_q.push_back(8'h22);
    run(1, 0, 1'b0, 100);
    chk("iq_beat0", obs_log[0], {17'h14AB5, 2'b10});
    chk("iq_beat1", obs_log[1], {17'h02245, 2'b01});
    for (int i = 0; i < 24; i++) src_q.push_back(8'($urandom));
    run(1, 30, 1'b1, 2000);

    // One-beat packets through the 16-bit counter wrap
    for (int i = 0; i < 65537; i++) src_q.push_back(8'($urandom));
    run(2, 0, 1'b0, 70000);
    chk("wrap_cnt", pkt_cnt[2], 16'd1);

    // Asynchronous reset in the middle of a packet
    for (int i = 0; i < 2; i++) src_q.push_back(8'($urandom));
    run(0, 0, 1'b0, 100);
    in_valid[0]  = 1'b1;
    in_data[0]   = 8'h33;
    out_ready[0] = 1'b0;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    chk("pre_reset_valid", out_valid[0], 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero(0);
    model_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    chk("rel_ready_before", in_ready[0], 0);
    @(posedge clk);
    #1;
    chk("rel_ready_after", in_ready[0], 1);
    for (int i = 0; i < 4; i++) src_q.push_back(8'($urandom));
    run(0, 0, 1'b0, 100);
    chk("post_reset_sop", obs_log[0][1], 1);
    chk("post_reset_eop", obs_log[3][0], 1);

`ifdef FRAMER_PAD_EN
    // One beat then a flush pulse pads the packet out with zero beats
    src_q.push_back(8'h5C);
    run(0, 0, 1'b0, 100);
    flush[0] = 1'b1;
    while (beat_idx[0] % plen[0] != 0) push_beat(0, 8'h00, 8'h00);
    @(posedge clk);
    #1;
    flush[0] = 1'b0;
    pad_mode = 1'b1;
    run(0, 0, 1'b0, 50);
    pad_mode = 1'b0;
    chk("pad_count", obs_log.size(), 3);
    chk("pad_last", obs_log[2], {17'h00001, 2'b01});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
